// File: rtl/l1a_match_tag.sv
// l1a_match_tag: retimes L1A onto the LCT match strobe and queues {match, event number} tags in a FWFT FIFO.
module l1a_match_tag #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             L1A,
    input  logic             L1A_MATCH,
    input  logic [3:0]       L1FD,
    input  logic             RD_EN,
    output logic [CNT_W:0]   EVT_DATA,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVFL,
    output logic             ORPHAN,
    output logic [15:0]      MATCH_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0]      dly_q, dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      occ_q, occ_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             ovfl_q, ovfl_d, orphan_q, orphan_d;
    logic [15:0]      mcnt_q, mcnt_d;
    logic [CNT_W:0]   mem_q [FIFO_DEPTH];
    logic             al, pop, push;
    logic [CNT_W:0]   tag;

    always_comb begin
        dly_d    = {dly_q[14:0], L1A};
        al       = dly_q[L1FD];
        pop      = RD_EN && !empty_q;
        // a simultaneous pop frees the slot, so a full FIFO still accepts the write
        push     = al && (!full_q || pop);
        tag      = {L1A_MATCH, cnt_q + CNT_W'(1)};
        cnt_d    = al ? cnt_q + CNT_W'(1) : cnt_q;
        wp_d     = push ? wp_q + AW'(1) : wp_q;
        rp_d     = pop ? rp_q + AW'(1) : rp_q;
        occ_d    = (push && !pop) ? occ_q + (AW+1)'(1) :
                   (pop && !push) ? occ_q - (AW+1)'(1) : occ_q;
        empty_d  = occ_d == '0;
        full_d   = occ_d == (AW+1)'(FIFO_DEPTH);
        ovfl_d   = ovfl_q || (al && !push);
        orphan_d = orphan_q || (L1A_MATCH && !al);
        mcnt_d   = (push && L1A_MATCH && mcnt_q != 16'hFFFF) ? mcnt_q + 16'd1 : mcnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dly_q    <= '0;
            cnt_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            occ_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            orphan_q <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            dly_q    <= dly_d;
            cnt_q    <= cnt_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            occ_q    <= occ_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovfl_q   <= ovfl_d;
            orphan_q <= orphan_d;
            mcnt_q   <= mcnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST)
            mem_q[wp_q] <= tag;
    end

    assign EVT_DATA  = empty_q ? '0 : mem_q[rp_q];
    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign OVFL      = ovfl_q;
    assign ORPHAN    = orphan_q;
    assign MATCH_CNT = mcnt_q;
endmodule
